// File: rtl/cr_had_dbgreq_arb.sv
`default_nettype none
// ============================================================================
// Module      : cr_had_dbgreq_arb
// Description : HAD debug-request arbiter for NUM_BKPT breakpoint channels.
//               Prioritises sync/async debug requests, memory breakpoints and
//               trace. Holds the debug request towards the IU until debug mode
//               is entered or an acknowledge timeout expires. Runs the
//               entry/exit FSM and reports the entry cause and breakpoint index.
// Ports       : cpuclk / hadrst                   clock, async active-high reset
//               bkpt_ctrl_req / _ifetch_req       per-channel data / ifetch hits
//               regs_ctrl_mbee                    per-channel "exception, not debug"
//               regs_ctrl_dr / _adr               forced sync / async requests
//               sysio_had_sdb_req_b               system sync request (active-low)
//               pin_ctrl_jdb_req, trace_ctrl_req  pin async / trace requests
//               regs_ctrl_had_int_on,
//               iu_had_dbg_disable_for_tee        mask every breakpoint source
//               iu_yy_xx_dbgon                    CPU is in debug mode
//               iu_had_xx_bkpt_inst               software bkpt retired
//               regs_ctrl_hacr_ex/_go, regs_ctrl_exit_sel,
//               jtag_xx_update_dr                 exit command qualifiers
//               had_iu_dbg_req                    held debug request to IU
//               had_iu_mem_bkpt_exp_req           one-cycle bkpt exception pulse
//               had_ifu_inst_bkpt_dbq_req/_dbqexp_req  ifetch bkpt requests
//               had_yy_xx_dbg                     wake-up indication
//               had_yy_xx_exit_dbg                one-cycle exit pulse
//               ctrl_regs_cause/_bkpt_idx         cause / channel of last entry
//               ctrl_regs_cause_vld               entry-complete pulse
//               ctrl_regs_ack_timeout             sticky ack-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module cr_had_dbgreq_arb #(
  parameter int NUM_BKPT    = 5,
  parameter int IDX_W       = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                cpuclk,
  input  logic                hadrst,
  input  logic [NUM_BKPT-1:0] bkpt_ctrl_req,
  input  logic [NUM_BKPT-1:0] bkpt_ctrl_ifetch_req,
  input  logic [NUM_BKPT-1:0] regs_ctrl_mbee,
  input  logic                regs_ctrl_dr,
  input  logic                regs_ctrl_adr,
  input  logic                sysio_had_sdb_req_b,
  input  logic                pin_ctrl_jdb_req,
  input  logic                trace_ctrl_req,
  input  logic                regs_ctrl_had_int_on,
  input  logic                iu_had_dbg_disable_for_tee,
  input  logic                iu_yy_xx_dbgon,
  input  logic                iu_had_xx_bkpt_inst,
  input  logic                regs_ctrl_hacr_ex,
  input  logic                regs_ctrl_hacr_go,
  input  logic                regs_ctrl_exit_sel,
  input  logic                jtag_xx_update_dr,
  output logic                had_iu_dbg_req,
  output logic                had_iu_mem_bkpt_exp_req,
  output logic                had_ifu_inst_bkpt_dbq_req,
  output logic                had_ifu_inst_bkpt_dbqexp_req,
  output logic                had_yy_xx_dbg,
  output logic                had_yy_xx_exit_dbg,
  output logic [2:0]          ctrl_regs_cause,
  output logic [IDX_W-1:0]    ctrl_regs_bkpt_idx,
  output logic                ctrl_regs_cause_vld,
  output logic                ctrl_regs_ack_timeout
);

  // Counter is wide enough to hold ACK_TIMEOUT; with ACK_TIMEOUT==0 it simply
  // saturates and is never compared.
  localparam int               CNT_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_LAST   = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);
  localparam bit               TIMEOUT_EN = (ACK_TIMEOUT != 0);

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_DR     = 3'd1;
  localparam logic [2:0] CAUSE_SDB    = 3'd2;
  localparam logic [2:0] CAUSE_JDB    = 3'd3;
  localparam logic [2:0] CAUSE_MBKPT  = 3'd4;
  localparam logic [2:0] CAUSE_TRACE  = 3'd5;
  localparam logic [2:0] CAUSE_SWBKPT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DBG  = 2'd2,
    ST_EXIT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           cause_q, cause_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 vld_q, vld_d;
  logic                 exp_q, exp_d;
  logic                 exit_q, exit_d;
  logic                 ack_to_q, ack_to_d;
  logic                 dbgon_q;

  logic                 bkpt_mask;
  logic [NUM_BKPT-1:0]  mbkpt_vec;
  logic [NUM_BKPT-1:0]  mexp_vec;
  logic [IDX_W-1:0]     mbkpt_idx;
  logic [2:0]           src_cause;
  logic                 src_any;
  logic                 dbgon_rise;
  logic                 exit_cond;

  // Breakpoint sources are silenced entirely while interrupts-on or TEE
  // debug-disable is active.
  assign bkpt_mask = regs_ctrl_had_int_on | iu_had_dbg_disable_for_tee;
  assign mbkpt_vec = bkpt_ctrl_req & ~regs_ctrl_mbee & {NUM_BKPT{~bkpt_mask}};
  assign mexp_vec  = bkpt_ctrl_req &  regs_ctrl_mbee & {NUM_BKPT{~bkpt_mask}};

  // Lowest-numbered debug-mode breakpoint channel wins.
  always_comb begin
    mbkpt_idx = '0;
    for (int i = NUM_BKPT - 1; i >= 0; i--) begin
      if (mbkpt_vec[i]) mbkpt_idx = IDX_W'(i);
    end
  end

  always_comb begin
    src_cause = CAUSE_NONE;
    if (regs_ctrl_dr)                         src_cause = CAUSE_DR;
    else if (!sysio_had_sdb_req_b)            src_cause = CAUSE_SDB;
    else if (pin_ctrl_jdb_req | regs_ctrl_adr) src_cause = CAUSE_JDB;
    else if (|mbkpt_vec)                      src_cause = CAUSE_MBKPT;
    else if (trace_ctrl_req)                  src_cause = CAUSE_TRACE;
  end

  assign src_any    = (src_cause != CAUSE_NONE);
  assign dbgon_rise = iu_yy_xx_dbgon & ~dbgon_q;
  assign exit_cond  = regs_ctrl_hacr_ex & regs_ctrl_hacr_go & jtag_xx_update_dr &
                      regs_ctrl_exit_sel & iu_yy_xx_dbgon;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    idx_d    = idx_q;
    vld_d    = 1'b0;
    exp_d    = 1'b0;
    exit_d   = 1'b0;
    // The sticky timeout flag is released by the registered exit pulse.
    ack_to_d = ack_to_q & ~exit_q;
    case (state_q)
      ST_IDLE: begin
        if (src_any && !iu_yy_xx_dbgon) begin
          state_d = ST_REQ;
          cause_d = src_cause;
          if (src_cause == CAUSE_MBKPT) idx_d = mbkpt_idx;
        end else if (dbgon_rise) begin
          // Debug mode entered without our request (e.g. software bkpt).
          state_d = ST_DBG;
          vld_d   = 1'b1;
          if (iu_had_xx_bkpt_inst) cause_d = CAUSE_SWBKPT;
        end else if (|mexp_vec) begin
          exp_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (iu_yy_xx_dbgon) begin
          state_d = ST_DBG;
          vld_d   = 1'b1;
          cnt_d   = '0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d  = ST_IDLE;
          ack_to_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DBG: begin
        if (exit_cond) begin
          state_d = ST_EXIT;
          exit_d  = 1'b1;
        end
      end
      ST_EXIT: begin
        if (!iu_yy_xx_dbgon) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpuclk or posedge hadrst) begin
    if (hadrst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cause_q  <= CAUSE_NONE;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      exp_q    <= 1'b0;
      exit_q   <= 1'b0;
      ack_to_q <= 1'b0;
      dbgon_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      exp_q    <= exp_d;
      exit_q   <= exit_d;
      ack_to_q <= ack_to_d;
      dbgon_q  <= iu_yy_xx_dbgon;
    end
  end

  assign had_iu_dbg_req          = (state_q == ST_REQ);
  assign had_iu_mem_bkpt_exp_req = exp_q;
  assign had_yy_xx_exit_dbg      = exit_q;
  assign ctrl_regs_cause         = cause_q;
  assign ctrl_regs_bkpt_idx      = idx_q;
  assign ctrl_regs_cause_vld     = vld_q;
  assign ctrl_regs_ack_timeout   = ack_to_q;

  // Combinational outputs are forced low during reset so that every output
  // reads zero while hadrst is asserted.
  assign had_ifu_inst_bkpt_dbq_req    = ~hadrst & ~bkpt_mask &
                                        (|(bkpt_ctrl_ifetch_req & ~regs_ctrl_mbee));
  assign had_ifu_inst_bkpt_dbqexp_req = ~hadrst & ~bkpt_mask &
                                        (|(bkpt_ctrl_ifetch_req & regs_ctrl_mbee));
  assign had_yy_xx_dbg                = ~hadrst & (regs_ctrl_dr | ~sysio_had_sdb_req_b |
                                                   pin_ctrl_jdb_req | regs_ctrl_adr);

endmodule
`default_nettype wire
